// File: rtl/logicnet_input_quantizer_pkg.sv
// Shared constants, helpers and state type for the LogicNets input quantizer
// and the registered truth-table layer wrappers.
package logicnet_input_quantizer_pkg;

    localparam int DEF_NUM_FEATURES = 4;
    localparam int DEF_IN_WIDTH     = 8;
    localparam int DEF_Q_BITS       = 2;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic int num_thresholds(input int q_bits);
        return (32'sd1 <<< q_bits) - 32'sd1;
    endfunction

    function automatic int clog2(input int n);
        int r;
        int p;
        r = 32'sd0;
        p = 32'sd1;
        for (int i = 0; i < 31; i++) begin
            if (p < n) begin
                r = i + 32'sd1;
            end else begin
                r = r;
            end
            p = p * 32'sd2;
        end
        return r;
    endfunction

    // T0 lands in the LSBs so threshold i sits at [i*8 +: 8].
    function automatic logic [23:0] pack_thresholds_3x8(input logic [7:0] t0,
                                                        input logic [7:0] t1,
                                                        input logic [7:0] t2);
        return {t2, t1, t0};
    endfunction

endpackage

// File: rtl/logicnet_input_quantizer_threshold_quant.sv
// Combinational comparator bank: code = number of thresholds the sample meets or exceeds.
module logicnet_threshold_quant
    import logicnet_input_quantizer_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int Q_BITS   = DEF_Q_BITS,
    parameter logic [((2**Q_BITS)-1)*IN_WIDTH-1:0] THRESHOLDS =
        pack_thresholds_3x8(8'd64, 8'd128, 8'd192)
) (
    input  logic [IN_WIDTH-1:0] i_data,
    output logic [Q_BITS-1:0]   o_code
);

    localparam int NUM_THR = num_thresholds(Q_BITS);

    logic [Q_BITS-1:0] w_count;

    // Ascending thresholds keep the count within Q_BITS without explicit saturation.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_THR; i++) begin
            if (i_data >= THRESHOLDS[i*IN_WIDTH +: IN_WIDTH]) begin
                w_count = w_count + Q_BITS'(1'b1);
            end else begin
                w_count = w_count;
            end
        end
    end

    assign o_code = w_count;

endmodule

// File: rtl/logicnet_input_quantizer.sv
// Streaming sample quantizer: packs one frame of codes into a registered,
// handshaked vector for the first truth-table layer, with sticky framing error.
module logicnet_input_quantizer
    import logicnet_input_quantizer_pkg::*;
#(
    parameter int NUM_FEATURES = DEF_NUM_FEATURES,
    parameter int IN_WIDTH     = DEF_IN_WIDTH,
    parameter int Q_BITS       = DEF_Q_BITS,
    parameter logic [((2**Q_BITS)-1)*IN_WIDTH-1:0] THRESHOLDS =
        pack_thresholds_3x8(8'd64, 8'd128, 8'd192)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_s_valid,
    output logic                           o_s_ready,
    input  logic [IN_WIDTH-1:0]            i_s_data,
    input  logic                           i_s_last,
    output logic                           o_m_valid,
    input  logic                           i_m_ready,
    output logic [NUM_FEATURES*Q_BITS-1:0] o_m_data,
    output logic                           o_err
);

    localparam int VW    = NUM_FEATURES * Q_BITS;
    localparam int IDX_W = clog2(NUM_FEATURES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    state_e            r_state;
    logic              r_s_ready;
    logic [IDX_W-1:0]  r_idx;
    logic [VW-1:0]     r_shadow;
    logic              r_m_valid;
    logic [VW-1:0]     r_m_data;
    logic              r_err;

    state_e            w_next_state;
    logic [Q_BITS-1:0] w_code;
    logic [VW-1:0]     w_vector;
    logic [VW-1:0]     w_load_data;
    logic              w_load;
    logic              w_accept;
    logic              w_drain;
    logic              w_complete;
    logic              w_out_free;

    logicnet_threshold_quant #(
        .IN_WIDTH   (IN_WIDTH),
        .Q_BITS     (Q_BITS),
        .THRESHOLDS (THRESHOLDS)
    ) u_quant (
        .i_data (i_s_data),
        .o_code (w_code)
    );

    assign w_accept   = i_s_valid && r_s_ready;
    assign w_drain    = r_m_valid && i_m_ready;
    assign w_complete = w_accept && (r_idx == LAST_IDX);
    assign w_out_free = !r_m_valid || w_drain;

    // Shadow vector with the incoming code merged into the current slot.
    always_comb begin
        w_vector = r_shadow;
        w_vector[r_idx*Q_BITS +: Q_BITS] = w_code;
    end

    // Next-state and output-register load decision.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_data  = w_vector;
        case (r_state)
            ST_FILL: begin
                if (w_complete) begin
                    if (w_out_free) begin
                        w_load = 1'b1;
                    end else begin
                        w_next_state = ST_HOLD;
                    end
                end else begin
                    w_next_state = ST_FILL;
                end
            end
            ST_HOLD: begin
                if (w_drain) begin
                    w_next_state = ST_FILL;
                    w_load       = 1'b1;
                    w_load_data  = r_shadow;
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            default: begin
                w_next_state = ST_FILL;
            end
        endcase
    end

    // State, counter, shadow, output register and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FILL;
            r_s_ready <= 1'b0;
            r_idx     <= '0;
            r_shadow  <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            // Registered decode keeps m_ready off any combinational path to s_ready.
            r_s_ready <= (w_next_state == ST_FILL);
            if (w_accept) begin
                r_shadow <= w_vector;
                if (w_complete || i_s_last) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1'b1);
                end
            end
            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_load_data;
            end else if (w_drain) begin
                r_m_valid <= 1'b0;
            end
            if (w_accept && (i_s_last != w_complete)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_s_ready = r_s_ready;
    assign o_m_valid = r_m_valid;
    assign o_m_data  = r_m_data;
    assign o_err     = r_err;

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Self-checking bench: frame-level behavioural model, directed plan cases, random traffic.
module tb_logicnet_input_quantizer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_s_valid = 1'b0;
    logic       o_s_ready;
    logic [7:0] i_s_data = 8'd0;
    logic       i_s_last = 1'b0;
    logic       o_m_valid;
    logic       i_m_ready = 1'b0;
    logic [7:0] o_m_data;
    logic       o_err;

    int n_pass  = 0;
    int n_total = 0;

    // Model: what the outputs must show after the most recent rising edge.
    bit         md_s_ready;
    bit         md_out_valid;
    bit         md_hold;
    bit         md_err;
    logic [7:0] md_out;
    logic [7:0] md_pend;
    int         codes[$];

    logicnet_input_quantizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_s_valid (i_s_valid),
        .o_s_ready (o_s_ready),
        .i_s_data  (i_s_data),
        .i_s_last  (i_s_last),
        .o_m_valid (o_m_valid),
        .i_m_ready (i_m_ready),
        .o_m_data  (o_m_data),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int quant(input int d);
        int thr[3] = '{64, 128, 192};
        int c = 0;
        foreach (thr[i]) begin
            if (d >= thr[i]) c++;
        end
        return c;
    endfunction

    function automatic void model_reset();
        md_s_ready   = 1'b0;
        md_out_valid = 1'b0;
        md_hold      = 1'b0;
        md_err       = 1'b0;
        md_out       = 8'd0;
        md_pend      = 8'd0;
        codes.delete();
    endfunction

    function automatic void model_step(input bit v, input int d, input bit l, input bit mr);
        bit         acc   = v && md_s_ready;
        bit         drain = md_out_valid && mr;
        bit         done  = 1'b0;
        logic [7:0] vec   = 8'd0;
        logic [7:0] tmp;
        if (acc) begin
            codes.push_back(quant(d));
            if (codes.size() == N) begin
                for (int k = 0; k < N; k++) begin
                    tmp = 8'(codes[k]);
                    vec = vec | (tmp << (2 * k));
                end
                done = 1'b1;
                if (!l) md_err = 1'b1;
                codes.delete();
            end else if (l) begin
                md_err = 1'b1;
                codes.delete();
            end
        end
        if (md_hold) begin
            if (drain) begin
                md_out  = md_pend;
                md_hold = 1'b0;
            end
        end else if (done) begin
            if (!md_out_valid || drain) begin
                md_out       = vec;
                md_out_valid = 1'b1;
            end else begin
                md_hold = 1'b1;
                md_pend = vec;
            end
        end else if (drain) begin
            md_out_valid = 1'b0;
        end
        md_s_ready = !md_hold;
    endfunction

    // One clock: compare outputs against the model, then drive and advance the model.
    task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit mr);
        @(negedge clk);
        chk("s_ready", o_s_ready, md_s_ready);
        chk("m_valid", o_m_valid, md_out_valid);
        chk("err", o_err, md_err);
        if (md_out_valid) chk("m_data", o_m_data, md_out);
        i_s_valid = v;
        i_s_data  = d;
        i_s_last  = l;
        i_m_ready = mr;
        model_step(v, int'(d), l, mr);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] e, input bit last_at_end, input bit mr);
        cycle(1'b1, a, 1'b0, mr);
        cycle(1'b1, b, 1'b0, mr);
        cycle(1'b1, c, 1'b0, mr);
        cycle(1'b1, e, last_at_end, mr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        i_s_valid = 1'b0;
        i_s_last  = 1'b0;
        i_m_ready = 1'b0;
        #1;
        chk("rst_s_ready", o_s_ready, 32'd0);
        chk("rst_m_valid", o_m_valid, 32'd0);
        chk("rst_err", o_err, 32'd0);
        chk("rst_m_data", o_m_data, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_step(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Basic frame, one-cycle latency after the last accept.
        send_frame(8'd10, 8'd70, 8'd130, 8'd200, 1'b1, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b0);
        chk("basic_valid", o_m_valid, 32'd1);
        chk("basic_data", o_m_data, 32'hE4);
        chk("basic_err", o_err, 32'd0);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);

        // Threshold edges.
        send_frame(8'd255, 8'd0, 8'd128, 8'd127, 1'b1, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        chk("edge_a_data", o_m_data, 32'h63);
        send_frame(8'd63, 8'd64, 8'd191, 8'd192, 1'b1, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        chk("edge_b_data", o_m_data, 32'hE4);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);

        // Backpressure: second frame parks in HOLD until a single-cycle m_ready.
        send_frame(8'd255, 8'd0, 8'd128, 8'd127, 1'b1, 1'b0);
        send_frame(8'd63, 8'd64, 8'd191, 8'd192, 1'b1, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0);
        chk("bp_valid", o_m_valid, 32'd1);
        chk("bp_first_data", o_m_data, 32'h63);
        chk("bp_hold_s_ready", o_s_ready, 32'd0);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        chk("bp_stable_data", o_m_data, 32'h63);
        cycle(1'b0, 8'd0, 1'b0, 1'b0);
        chk("bp_second_data", o_m_data, 32'hE4);
        chk("bp_second_valid", o_m_valid, 32'd1);
        chk("bp_s_ready_back", o_s_ready, 32'd1);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);

        // Early s_last discards the partial frame.
        cycle(1'b1, 8'd10, 1'b0, 1'b1);
        cycle(1'b1, 8'd70, 1'b1, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        chk("early_no_valid", o_m_valid, 32'd0);
        chk("early_err", o_err, 32'd1);
        send_frame(8'd10, 8'd70, 8'd130, 8'd200, 1'b1, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b0);
        chk("early_next_data", o_m_data, 32'hE4);
        chk("early_next_valid", o_m_valid, 32'd1);

        do_reset();

        // Missing s_last: vector still emitted, error raised.
        send_frame(8'd10, 8'd70, 8'd130, 8'd200, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0);
        chk("nolast_valid", o_m_valid, 32'd1);
        chk("nolast_data", o_m_data, 32'hE4);
        chk("nolast_err", o_err, 32'd1);

        // Reset mid-frame with a vector still pending downstream.
        cycle(1'b1, 8'd255, 1'b0, 1'b0);
        cycle(1'b1, 8'd0, 1'b0, 1'b0);
        do_reset();
        send_frame(8'd255, 8'd0, 8'd128, 8'd127, 1'b1, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        chk("post_rst_data", o_m_data, 32'h63);
        chk("post_rst_valid", o_m_valid, 32'd1);

        // Random traffic with occasional framing faults and resets.
        for (int t = 0; t < 3000; t++) begin
            bit         v;
            bit         l;
            bit         mr;
            logic [7:0] d;
            v  = ($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
            l  = (codes.size() == N - 1) ^ ($urandom_range(0, 19) == 0);
            mr = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle(v, d, l, mr);
            end
        end
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
